// File: rtl/oled_sched_pkg.sv
// rtl/oled_sched_pkg.sv - shared types and constants for the OLED page scheduler
// Purpose: scheduler state enum, text buffer geometry and index typedefs.
// Ports: none (package).
package oled_sched_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        ARB       = 2'd1,
        REFRESH   = 2'd2,
        REARM     = 2'd3
    } state_t;

    localparam int          PAGES  = 4;
    localparam int          COLS   = 16;
    localparam int          CHAR_W = 8;
    localparam logic [7:0]  SPACE  = 8'h20;

    typedef logic [1:0] page_idx_t;
    typedef logic [3:0] col_idx_t;

endpackage

// File: rtl/oled_page_scheduler_rr_arbiter.sv
// rtl/oled_page_scheduler_rr_arbiter.sv - round-robin arbiter for character writers
// Purpose: grants at most one requester per cycle, searching from the index
//          after the most recent grant.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   req[N]     request vector
//   advance    grants allowed this cycle
//   gnt[N]     one-hot grant (combinational, zero when advance=0)
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Index searched first: one past the last granted requester.
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;

    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        ptr_next = ptr;
        // Outer loop walks priority order; inner loop maps it onto a bit.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && advance && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    gnt[j]   = 1'b1;
                    found    = 1'b1;
                    ptr_next = PW'((j + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/oled_page_scheduler.sv
// rtl/oled_page_scheduler.sv - shared OLED text buffer with refresh sequencing
// Purpose: round-robin character writes into a 4x16 text buffer and
//          rate-limited EN/FIN refresh transactions to the display engine.
// Optional feature macro: OLED_SCHED_STATS_EN adds refresh_cnt / write_cnt.
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   init_done              display init finished (level)
//   req/req_page/req_col/req_char  per-requester write request and payload
//   gnt                    one-hot grant pulse; write lands on that edge
//   disp_en / disp_done    refresh handshake with the display engine
//   page0..page3           buffer contents, column 0 in [127:120]
//   busy                   high in REFRESH and REARM
//   refresh_cnt, write_cnt (stats build only) wrapping event counters
import oled_sched_pkg::*;

module oled_page_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int HOLDOFF_CYC = 1_000_000,
    parameter int HOLDOFF_W   = 20
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   init_done,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_page,
    input  logic [4*NUM_REQ-1:0]   req_col,
    input  logic [8*NUM_REQ-1:0]   req_char,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   disp_en,
    input  logic                   disp_done,
    output logic [127:0]           page0,
    output logic [127:0]           page1,
    output logic [127:0]           page2,
    output logic [127:0]           page3,
    output logic                   busy
`ifdef OLED_SCHED_STATS_EN
    ,
    output logic [15:0]            refresh_cnt,
    output logic [15:0]            write_cnt
`endif
);

    state_t                 state;
    logic                   dirty;
    logic [HOLDOFF_W-1:0]   holdoff;
    logic [CHAR_W-1:0]      buf_q [PAGES][COLS];

    logic                   any_gnt;
    page_idx_t              wr_page;
    col_idx_t               wr_col;
    logic [CHAR_W-1:0]      wr_char;

    // Grants only exist in ARB, so the buffer is implicitly frozen in REFRESH.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .advance (state == ARB),
        .gnt     (gnt)
    );

    assign any_gnt = |gnt;

    always_comb begin
        wr_page = '0;
        wr_col  = '0;
        wr_char = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wr_page = req_page[2*i +: 2];
                wr_col  = req_col[4*i +: 4];
                wr_char = req_char[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < PAGES; p++) begin
                for (int c = 0; c < COLS; c++) begin
                    buf_q[p][c] <= SPACE;
                end
            end
        end else if (any_gnt) begin
            buf_q[wr_page][wr_col] <= wr_char;
        end
    end

    always_comb begin
        page0 = '0;
        page1 = '0;
        page2 = '0;
        page3 = '0;
        for (int c = 0; c < COLS; c++) begin
            page0[(COLS-1-c)*CHAR_W +: CHAR_W] = buf_q[0][c];
            page1[(COLS-1-c)*CHAR_W +: CHAR_W] = buf_q[1][c];
            page2[(COLS-1-c)*CHAR_W +: CHAR_W] = buf_q[2][c];
            page3[(COLS-1-c)*CHAR_W +: CHAR_W] = buf_q[3][c];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= WAIT_INIT;
            disp_en <= 1'b0;
            busy    <= 1'b0;
            dirty   <= 1'b1;
            holdoff <= '0;
        end else begin
            // Holdoff is paused while the engine is drawing.
            if (state != REFRESH && holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end
            case (state)
                WAIT_INIT: begin
                    if (init_done) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (any_gnt) begin
                        dirty <= 1'b1;
                    end
                    if (!init_done) begin
                        state <= WAIT_INIT;
                        dirty <= 1'b1;
                    end else if (!any_gnt && dirty && holdoff == '0) begin
                        // A grant this cycle pushes the refresh decision out one cycle.
                        state   <= REFRESH;
                        disp_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REFRESH: begin
                    if (disp_done) begin
                        state   <= REARM;
                        disp_en <= 1'b0;
                        dirty   <= 1'b0;
                        holdoff <= HOLDOFF_W'(HOLDOFF_CYC);
                    end
                end
                REARM: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= WAIT_INIT;
                    disp_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef OLED_SCHED_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            refresh_cnt <= '0;
            write_cnt   <= '0;
        end else begin
            if (state == REFRESH && disp_done) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
            if (any_gnt) begin
                write_cnt <= write_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_oled_page_scheduler.sv
// tb/tb_oled_page_scheduler.sv - self-checking bench for oled_page_scheduler
module tb_oled_page_scheduler;

    localparam int N  = 3;
    localparam int HC = 20;
    localparam int HW = 5;

    localparam int M_WAIT  = 0;
    localparam int M_ARB   = 1;
    localparam int M_REF   = 2;
    localparam int M_REARM = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic           init_done;
    logic [N-1:0]   req;
    logic [2*N-1:0] req_page;
    logic [4*N-1:0] req_col;
    logic [8*N-1:0] req_char;
    logic [N-1:0]   gnt;
    logic           disp_en;
    logic           disp_done;
    logic [127:0]   page0, page1, page2, page3;
    logic           busy;
`ifdef OLED_SCHED_STATS_EN
    logic [15:0]    refresh_cnt;
    logic [15:0]    write_cnt;
`endif

    always #5 CLK = ~CLK;

    oled_page_scheduler #(
        .NUM_REQ     (N),
        .HOLDOFF_CYC (HC),
        .HOLDOFF_W   (HW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .req       (req),
        .req_page  (req_page),
        .req_col   (req_col),
        .req_char  (req_char),
        .gnt       (gnt),
        .disp_en   (disp_en),
        .disp_done (disp_done),
        .page0     (page0),
        .page1     (page1),
        .page2     (page2),
        .page3     (page3),
        .busy      (busy)
`ifdef OLED_SCHED_STATS_EN
        ,
        .refresh_cnt (refresh_cnt),
        .write_cnt   (write_cnt)
`endif
    );

    typedef struct {
        logic       init;
        logic [2:0] rq;
        logic       done;
        logic [2:0] egnt;
        logic       een;
        logic       ebusy;
        int         pg;
        int         col;
        logic [7:0] ch;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: the text buffer as a 2-D byte array plus a few counters.
    int         m_mode;
    bit         m_dirty;
    int         m_hold;
    int         m_ptr;
    logic [7:0] m_buf [4][16];
    int         m_rcnt;
    int         m_wcnt;

    function automatic void add(input logic init, input logic [2:0] rq, input logic done,
                                input logic [2:0] egnt, input logic een, input logic ebusy,
                                input int pg = -1, input int col = 0, input logic [7:0] ch = 8'h00);
        vec_t v;
        v.init = init; v.rq = rq; v.done = done;
        v.egnt = egnt; v.een = een; v.ebusy = ebusy;
        v.pg = pg; v.col = col; v.ch = ch;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        m_mode  = M_WAIT;
        m_dirty = 1'b1;
        m_hold  = 0;
        m_ptr   = 0;
        m_rcnt  = 0;
        m_wcnt  = 0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 16; c++)
                m_buf[p][c] = 8'h20;
    endtask

    function automatic int model_gnt(input logic [N-1:0] r);
        if (m_mode != M_ARB) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int g);
        logic [2:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] model_page(input int p);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[(15-c)*8 +: 8] = m_buf[p][c];
        return v;
    endfunction

    function automatic logic [127:0] dut_page(input int p);
        case (p)
            0:       return page0;
            1:       return page1;
            2:       return page2;
            default: return page3;
        endcase
    endfunction

    task automatic model_step(input int g);
        bit old_dirty;
        int old_hold;
        old_dirty = m_dirty;
        old_hold  = m_hold;
        if (g >= 0) begin
            m_buf[req_page[2*g +: 2]][req_col[4*g +: 4]] = req_char[8*g +: 8];
            m_dirty = 1'b1;
            m_ptr   = (g + 1) % N;
            m_wcnt  = (m_wcnt + 1) % 65536;
        end
        if (m_mode != M_REF && m_hold > 0) m_hold = m_hold - 1;
        case (m_mode)
            M_WAIT:  if (init_done) m_mode = M_ARB;
            M_ARB: begin
                if (!init_done) begin
                    m_mode  = M_WAIT;
                    m_dirty = 1'b1;
                end else if (g < 0 && old_dirty && old_hold == 0) begin
                    m_mode = M_REF;
                end
            end
            M_REF: begin
                if (disp_done) begin
                    m_mode  = M_REARM;
                    m_dirty = 1'b0;
                    m_hold  = HC;
                    m_rcnt  = (m_rcnt + 1) % 65536;
                end
            end
            default: m_mode = M_ARB;
        endcase
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_cycle(input logic [2:0] egnt, input logic een, input logic ebusy);
        chk("gnt", 128'(gnt), 128'(egnt));
        chk("disp_en", 128'(disp_en), 128'(een));
        chk("busy", 128'(busy), 128'(ebusy));
        for (int p = 0; p < 4; p++) chk($sformatf("page%0d", p), dut_page(p), model_page(p));
`ifdef OLED_SCHED_STATS_EN
        chk("refresh_cnt", 128'(refresh_cnt), 128'(m_rcnt));
        chk("write_cnt", 128'(write_cnt), 128'(m_wcnt));
`endif
    endtask

    initial begin
        logic [127:0] pv;
        int           g;

        RST = 1'b1; init_done = 1'b0; req = '0; disp_done = 1'b0;
        req_page = {2'd3, 2'd2, 2'd1};
        req_col  = {4'd15, 4'd5, 4'd0};
        req_char = {8'h43, 8'h42, 8'h41};
        model_reset();

        // Directed timeline: reset, first refresh, writes, holdoff, round-robin.
        for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 3'b000, 0, 0);
        add(0, 3'b010, 0, 3'b000, 0, 0);                 // no grant in WAIT_INIT
        add(0, 3'b000, 0, 3'b000, 0, 0);
        add(1, 3'b000, 0, 3'b000, 0, 0);                 // init_done seen
        add(1, 3'b000, 0, 3'b000, 0, 0);                 // ARB, dirty from reset
        add(1, 3'b010, 0, 3'b000, 1, 1);                 // REFRESH blocks grant
        add(1, 3'b010, 1, 3'b000, 1, 1);                 // FIN
        add(1, 3'b010, 0, 3'b000, 0, 1);                 // REARM
        add(1, 3'b010, 0, 3'b010, 0, 0);                 // first ARB grants req1
        add(1, 3'b000, 0, 3'b000, 0, 0, 2, 5, 8'h42);
        for (int i = 0; i < 16; i++) add(1, 3'b000, 0, 3'b000, 0, 0);
        add(1, 3'b001, 0, 3'b001, 0, 0);                 // write as holdoff hits 0
        add(1, 3'b000, 0, 3'b000, 0, 0, 1, 0, 8'h41);
        add(1, 3'b100, 0, 3'b000, 1, 1);
        add(1, 3'b100, 1, 3'b000, 1, 1);
        add(1, 3'b100, 0, 3'b000, 0, 1);
        add(1, 3'b100, 0, 3'b100, 0, 0);
        add(1, 3'b111, 0, 3'b001, 0, 0);
        add(1, 3'b111, 0, 3'b010, 0, 0);
        add(1, 3'b111, 0, 3'b100, 0, 0);
        add(1, 3'b111, 0, 3'b001, 0, 0);
        for (int i = 0; i < 14; i++) add(1, 3'b000, 0, 3'b000, 0, 0);  // dirty but held off
        add(1, 3'b010, 0, 3'b010, 0, 0);                 // grant defers refresh
        add(1, 3'b000, 0, 3'b000, 0, 0);
        add(1, 3'b000, 0, 3'b000, 1, 1);

        repeat (2) @(negedge CLK);
        #1;
        check_cycle(3'b000, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            @(negedge CLK);
            RST       = 1'b0;
            init_done = tbl[i].init;
            req       = tbl[i].rq;
            disp_done = tbl[i].done;
            #1;
            g = model_gnt(req);
            check_cycle(tbl[i].egnt, tbl[i].een, tbl[i].ebusy);
            if (tbl[i].pg >= 0) begin
                pv = dut_page(tbl[i].pg);
                chk($sformatf("cell p%0d c%0d", tbl[i].pg, tbl[i].col),
                    128'(pv[(15-tbl[i].col)*8 +: 8]), 128'(tbl[i].ch));
            end
            model_step(g);
        end

        // Reset while the engine is drawing: outputs drop without a clock edge.
        @(negedge CLK);
        RST = 1'b1; req = '0; disp_done = 1'b0;
        #1;
        model_reset();
        check_cycle(3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 900; i++) begin
            @(negedge CLK);
            RST       = 1'b0;
            init_done = ($urandom_range(0, 31) != 0);
            req       = 3'($urandom);
            disp_done = ($urandom_range(0, 3) == 0);
            req_page  = 6'($urandom);
            req_col   = 12'($urandom);
            req_char  = 24'($urandom);
            #1;
            g = model_gnt(req);
            check_cycle(onehot(g), m_mode == M_REF, m_mode == M_REF || m_mode == M_REARM);
            model_step(g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
